// File: rtl/qspi_flash_sched.sv
// qspi_flash_sched: round-robin scheduler for two flash clients in front of qspi_driver.
// Expands each op into WREN / OP / RDSR1-poll driver commands separated by one idle cycle.
module qspi_flash_sched #(
  parameter logic [19:0] POLL_MAX = 20'd1000000
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [1:0]  I_req,
  input  logic [1:0]  I_op0,
  input  logic [1:0]  I_op1,
  input  logic [23:0] I_addr0,
  input  logic [23:0] I_addr1,
  output logic [1:0]  O_gnt,
  output logic [1:0]  O_done,
  output logic [1:0]  O_err,
  output logic        O_owner,
  output logic        O_busy,
  output logic [7:0]  O_rd_data,
  output logic        O_rd_valid,
  output logic [4:0]  O_cmd_type,
  output logic [7:0]  O_cmd_code,
  output logic [23:0] O_addr,
  input  logic        I_done_sig,
  input  logic [7:0]  I_read_data,
  input  logic        I_read_byte_valid
);
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WREN, S_OP, S_POLL, S_GAP, S_FIN} state_t;

  localparam logic [12:0] CMD_NONE = {5'b0_0000, 8'h00};
  localparam logic [12:0] CMD_WREN = {5'b1_0001, 8'h06};
  localparam logic [12:0] CMD_RDSR = {5'b1_0011, 8'h05};

  function automatic logic [12:0] op_cmd(input logic [1:0] op);
    case (op)
      2'd0:    op_cmd = {5'b1_0000, 8'h90};
      2'd1:    op_cmd = {5'b1_0111, 8'h03};
      2'd2:    op_cmd = {5'b1_0010, 8'h20};
      default: op_cmd = {5'b1_0101, 8'h02};
    endcase
  endfunction

  state_t      state_q, state_d, resume_q, resume_d;
  logic [1:0]  op_q, op_d, gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic        owner_q, owner_d, prio_q, prio_d, busy_q, busy_d;
  logic [12:0] cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [19:0] cnt_q, cnt_d;
  logic [20:0] cnt_inc;
  logic        pick, rd_phase;

  assign cnt_inc = {1'b0, cnt_q} + 21'd1;
  // prio_q names the client that wins a tie; it always points away from the last winner
  assign pick    = (I_req == 2'b11) ? prio_q : I_req[1];

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    op_d     = op_q;
    owner_d  = owner_q;
    prio_d   = prio_q;
    busy_d   = busy_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    gnt_d    = '0;
    done_d   = '0;
    err_d    = '0;
    case (state_q)
      S_IDLE: if (|I_req) begin
        state_d     = S_GRANT;
        gnt_d[pick] = 1'b1;
        owner_d     = pick;
        prio_d      = ~pick;
        op_d        = pick ? I_op1 : I_op0;
        addr_d      = pick ? I_addr1 : I_addr0;
        busy_d      = 1'b1;
        cnt_d       = '0;
      end
      S_GRANT: begin
        if (op_q[1]) begin
          state_d = S_WREN;
          cmd_d   = CMD_WREN;
        end else begin
          state_d = S_OP;
          cmd_d   = op_cmd(op_q);
        end
      end
      S_WREN: if (I_done_sig) begin
        state_d  = S_GAP;
        resume_d = S_OP;
        cmd_d    = CMD_NONE;
      end
      S_OP: if (I_done_sig) begin
        cmd_d = CMD_NONE;
        if (op_q[1]) begin
          state_d  = S_GAP;
          resume_d = S_POLL;
        end else begin
          state_d         = S_FIN;
          done_d[owner_q] = 1'b1;
        end
      end
      S_POLL: if (I_done_sig) begin
        cmd_d = CMD_NONE;
        cnt_d = cnt_inc[19:0];
        if (!I_read_data[0]) begin
          state_d         = S_FIN;
          done_d[owner_q] = 1'b1;
        end else if (cnt_inc >= {1'b0, POLL_MAX}) begin
          state_d        = S_FIN;
          err_d[owner_q] = 1'b1;
        end else begin
          state_d  = S_GAP;
          resume_d = S_POLL;
        end
      end
      S_GAP: begin
        state_d = resume_q;
        cmd_d   = (resume_q == S_POLL) ? CMD_RDSR : op_cmd(op_q);
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= S_IDLE;
      resume_q <= S_IDLE;
      op_q     <= '0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      busy_q   <= 1'b0;
      cmd_q    <= CMD_NONE;
      addr_q   <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      op_q     <= op_d;
      owner_q  <= owner_d;
      prio_q   <= prio_d;
      busy_q   <= busy_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // read bytes only count while the read itself is on the bus, never during status polls
  assign rd_phase   = (state_q == S_OP) && !op_q[1];
  assign O_rd_valid = rd_phase & I_read_byte_valid;
  assign O_rd_data  = rd_phase ? I_read_data : 8'h00;

  assign O_gnt      = gnt_q;
  assign O_done     = done_q;
  assign O_err      = err_q;
  assign O_owner    = owner_q;
  assign O_busy     = busy_q;
  assign O_cmd_type = cmd_q[12:8];
  assign O_cmd_code = cmd_q[7:0];
  assign O_addr     = addr_q;
endmodule
